pre_if_stage: RTL and testbench

//  Pre-IF stage of the LoongArch32 pipeline, directly upstream of if_stage. Owns PC generation and issues

---
 rtl/pre_if_stage.sv | 181 ++++++++++++++++++
 tb/tb_pre_if_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pre_if_stage.sv
// Pre-IF stage: PC generation, instruction-bus request handshake and redirect buffering
// for the LoongArch32 fetch front end.
module pre_if_stage #(
   parameter logic [31:0] RESET_PC        = 32'h1c00_0000,
   parameter int unsigned BR_BUS_WD       = 34,
   parameter int unsigned PS_TO_FS_BUS_WD = 49
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       fs_allowin,
   input  logic [BR_BUS_WD-1:0]       br_bus,
   input  logic                       wb_ex,
   input  logic                       wb_ertn_flush,
   input  logic [31:0]                ex_entry,
   input  logic [31:0]                ex_ra,
   output logic                       inst_sram_req,
   output logic                       inst_sram_wr,
   output logic [1:0]                 inst_sram_size,
   output logic [3:0]                 inst_sram_wstrb,
   output logic [31:0]                inst_sram_addr,
   output logic [31:0]                inst_sram_wdata,
   input  logic                       inst_sram_addr_ok,
   output logic                       ps_to_fs_valid,
   output logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus
);

   localparam int unsigned ECODE_W    = 6;
   localparam int unsigned ESUBCODE_W = 9;
   localparam logic [ECODE_W-1:0]    ECODE_ADE     = 6'h08;
   localparam logic [ESUBCODE_W-1:0] ESUBCODE_ADEF = 9'h000;
   localparam logic [ESUBCODE_W+ECODE_W-1:0] ADEF_CODE = {ESUBCODE_ADEF, ECODE_ADE};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] cur_pc_q, cur_pc_d;
   logic        cancel_q, cancel_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic        hold_ex_q, hold_ex_d;
   logic        hold_cancel_q, hold_cancel_d;
   logic        rd_buf_valid_q, rd_buf_valid_d;
   logic [31:0] rd_buf_target_q, rd_buf_target_d;
   logic        rd_buf_is_ex_q, rd_buf_is_ex_d;

   logic        br_taken;
   logic [31:0] br_target;
   logic        ex_redirect;
   logic [31:0] ex_target;
   logic        br_blocked;
   logic        redirect;
   logic [31:0] next_pc;
   logic        adef;
   logic        accept;
   logic        load_pc;
   logic        bus_cancel;
   logic        bus_ex;
   logic [31:0] bus_pc;
   logic        unused_br_taken_cancel;

   assign br_taken               = br_bus[32];
   assign br_target              = br_bus[31:0];
   assign unused_br_taken_cancel = br_bus[33];

   assign ex_redirect = wb_ex | wb_ertn_flush;
   assign ex_target   = wb_ex ? ex_entry : ex_ra;
   // A buffered exception target outranks any later branch (that branch is being flushed).
   assign br_blocked  = rd_buf_valid_q & rd_buf_is_ex_q;
   assign redirect    = ex_redirect | br_taken;
   assign adef        = (cur_pc_q[1:0] != 2'b00);
   assign accept      = inst_sram_addr_ok | adef;

   always_comb begin
      if (ex_redirect)                   next_pc = ex_target;
      else if (br_taken && !br_blocked)  next_pc = br_target;
      else if (rd_buf_valid_q)           next_pc = rd_buf_target_q;
      else                               next_pc = cur_pc_q + 32'd4;
   end

   // Next-state, entry selection and redirect buffering.
   always_comb begin
      state_d         = state_q;
      cur_pc_d        = cur_pc_q;
      cancel_d        = cancel_q | redirect;
      hold_pc_d       = hold_pc_q;
      hold_ex_d       = hold_ex_q;
      hold_cancel_d   = hold_cancel_q | redirect;
      rd_buf_valid_d  = rd_buf_valid_q;
      rd_buf_target_d = rd_buf_target_q;
      rd_buf_is_ex_d  = rd_buf_is_ex_q;
      inst_sram_req   = 1'b0;
      ps_to_fs_valid  = 1'b0;
      bus_cancel      = 1'b0;
      bus_ex          = 1'b0;
      bus_pc          = 32'd0;
      load_pc         = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
         end
         S_REQ: begin
            inst_sram_req  = ~adef;
            ps_to_fs_valid = accept;
            bus_cancel     = cancel_q | redirect;
            bus_ex         = adef;
            bus_pc         = cur_pc_q;
            if (accept) begin
               if (fs_allowin) begin
                  load_pc = 1'b1;
               end else begin
                  state_d       = S_HOLD;
                  hold_pc_d     = cur_pc_q;
                  hold_ex_d     = adef;
                  hold_cancel_d = cancel_q | redirect;
               end
            end
         end
         S_HOLD: begin
            ps_to_fs_valid = 1'b1;
            bus_cancel     = hold_cancel_q | redirect;
            bus_ex         = hold_ex_q;
            bus_pc         = hold_pc_q;
            if (fs_allowin) begin
               load_pc = 1'b1;
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (load_pc) begin
         cur_pc_d       = next_pc;
         cancel_d       = 1'b0;
         hold_cancel_d  = 1'b0;
         rd_buf_valid_d = 1'b0;
      end else if (ex_redirect || (br_taken && !br_blocked)) begin
         rd_buf_valid_d  = 1'b1;
         rd_buf_target_d = next_pc;
         rd_buf_is_ex_d  = ex_redirect;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         cur_pc_q        <= RESET_PC;
         cancel_q        <= 1'b0;
         hold_pc_q       <= 32'd0;
         hold_ex_q       <= 1'b0;
         hold_cancel_q   <= 1'b0;
         rd_buf_valid_q  <= 1'b0;
         rd_buf_target_q <= 32'd0;
         rd_buf_is_ex_q  <= 1'b0;
      end else begin
         state_q         <= state_d;
         cur_pc_q        <= cur_pc_d;
         cancel_q        <= cancel_d;
         hold_pc_q       <= hold_pc_d;
         hold_ex_q       <= hold_ex_d;
         hold_cancel_q   <= hold_cancel_d;
         rd_buf_valid_q  <= rd_buf_valid_d;
         rd_buf_target_q <= rd_buf_target_d;
         rd_buf_is_ex_q  <= rd_buf_is_ex_d;
      end
   end

   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = 2'd2;
   assign inst_sram_wstrb = 4'h0;
   assign inst_sram_wdata = 32'd0;
   assign inst_sram_addr  = cur_pc_q;
   assign ps_to_fs_bus    = PS_TO_FS_BUS_WD'({bus_cancel, bus_ex,
                                              (bus_ex ? ADEF_CODE : 15'd0), bus_pc});

endmodule

// File: tb/tb_pre_if_stage.sv
// Directed bench for pre_if_stage: fetch stream, stalls, HOLD, redirects, ADEF and reset.
module tb_pre_if_stage;

   logic        clk;
   logic        reset;
   logic        fs_allowin;
   logic [33:0] br_bus;
   logic        wb_ex;
   logic        wb_ertn_flush;
   logic [31:0] ex_entry;
   logic [31:0] ex_ra;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        inst_sram_addr_ok;
   logic        ps_to_fs_valid;
   logic [48:0] ps_to_fs_bus;

   int n_checks = 0;
   int n_errors = 0;

   pre_if_stage dut (
      .clk               (clk),
      .reset             (reset),
      .fs_allowin        (fs_allowin),
      .br_bus            (br_bus),
      .wb_ex             (wb_ex),
      .wb_ertn_flush     (wb_ertn_flush),
      .ex_entry          (ex_entry),
      .ex_ra             (ex_ra),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_wr      (inst_sram_wr),
      .inst_sram_size    (inst_sram_size),
      .inst_sram_wstrb   (inst_sram_wstrb),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_wdata   (inst_sram_wdata),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .ps_to_fs_valid    (ps_to_fs_valid),
      .ps_to_fs_bus      (ps_to_fs_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here, outputs checked #3 later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Forwarded entry fields: valid, cancel, ex, ex_code, pc.
   task automatic check_entry(input string tag, input logic v, input logic c, input logic e,
                              input logic [14:0] code, input logic [31:0] pc);
      check({tag, ".valid"},  64'(ps_to_fs_valid),      64'(v));
      check({tag, ".cancel"}, 64'(ps_to_fs_bus[48]),    64'(c));
      check({tag, ".ex"},     64'(ps_to_fs_bus[47]),    64'(e));
      check({tag, ".code"},   64'(ps_to_fs_bus[46:32]), 64'(code));
      check({tag, ".pc"},     64'(ps_to_fs_bus[31:0]),  64'(pc));
   endtask

   task automatic check_req(input string tag, input logic r, input logic [31:0] addr);
      check({tag, ".req"}, 64'(inst_sram_req), 64'(r));
      if (r) check({tag, ".addr"}, 64'(inst_sram_addr), 64'(addr));
   endtask

   initial begin
      reset = 1'b1; fs_allowin = 1'b1; br_bus = 34'd0; wb_ex = 1'b0; wb_ertn_flush = 1'b0;
      ex_entry = 32'd0; ex_ra = 32'd0; inst_sram_addr_ok = 1'b0;
      step(); step(); #3;
      check("rst.req", 64'(inst_sram_req), 64'd0);
      check("rst.valid", 64'(ps_to_fs_valid), 64'd0);
      check("rst.bus", 64'(ps_to_fs_bus), 64'd0);
      check("const.wr", 64'(inst_sram_wr), 64'd0);
      check("const.size", 64'(inst_sram_size), 64'd2);
      check("const.wstrb", 64'(inst_sram_wstrb), 64'd0);
      check("const.wdata", 64'(inst_sram_wdata), 64'd0);

      // First cycle after release is still IDLE.
      step(); reset = 1'b0; #3;
      check_req("idle", 1'b0, 32'd0);

      // Request stalled for three cycles: address stable, nothing forwarded.
      for (int i = 0; i < 3; i++) begin
         step(); inst_sram_addr_ok = 1'b0; #3;
         check_req("stall", 1'b1, 32'h1c00_0000);
         check("stall.valid", 64'(ps_to_fs_valid), 64'd0);
      end
      step(); inst_sram_addr_ok = 1'b1; #3;
      check_req("acc0", 1'b1, 32'h1c00_0000);
      check_entry("acc0", 1'b1, 1'b0, 1'b0, 15'd0, 32'h1c00_0000);
      step(); #3;
      check_entry("acc1", 1'b1, 1'b0, 1'b0, 15'd0, 32'h1c00_0004);
      step(); #3;
      check_entry("acc2", 1'b1, 1'b0, 1'b0, 15'd0, 32'h1c00_0008);

      // Branch while request stalled: buffered, current entry cancelled.
      step(); inst_sram_addr_ok = 1'b0; br_bus = {1'b0, 1'b1, 32'h1c00_0100}; #3;
      check_req("br.stall", 1'b1, 32'h1c00_000c);
      check("br.stall.valid", 64'(ps_to_fs_valid), 64'd0);
      step(); br_bus = 34'd0; #3;
      check_req("br.stall2", 1'b1, 32'h1c00_000c);
      step(); inst_sram_addr_ok = 1'b1; #3;
      check_entry("br.fwd", 1'b1, 1'b1, 1'b0, 15'd0, 32'h1c00_000c);
      step(); #3;
      check_req("br.new", 1'b1, 32'h1c00_0100);
      check_entry("br.new", 1'b1, 1'b0, 1'b0, 15'd0, 32'h1c00_0100);

      // IF not ready at accept: HOLD with stable bus, then exception cancels it.
      step(); fs_allowin = 1'b0; #3;
      check_entry("hold.acc", 1'b1, 1'b0, 1'b0, 15'd0, 32'h1c00_0104);
      step(); #3;
      check_req("hold", 1'b0, 32'd0);
      check_entry("hold", 1'b1, 1'b0, 1'b0, 15'd0, 32'h1c00_0104);
      step(); wb_ex = 1'b1; ex_entry = 32'h1c00_8000; #3;
      check_req("hold.ex", 1'b0, 32'd0);
      step(); wb_ex = 1'b0; #3;
      check_entry("hold.cancel", 1'b1, 1'b1, 1'b0, 15'd0, 32'h1c00_0104);
      step(); fs_allowin = 1'b1; #3;
      check_entry("hold.rel", 1'b1, 1'b1, 1'b0, 15'd0, 32'h1c00_0104);
      step(); #3;
      check_req("ex.new", 1'b1, 32'h1c00_8000);

      // ertn to a misaligned return address on the accept cycle: ADEF entry follows.
      wb_ertn_flush = 1'b1; ex_ra = 32'h1c00_0102; #1;
      check_entry("ertn.acc", 1'b1, 1'b1, 1'b0, 15'd0, 32'h1c00_8000);
      step(); wb_ertn_flush = 1'b0; inst_sram_addr_ok = 1'b0; #3;
      check_req("adef", 1'b0, 32'd0);
      check_entry("adef", 1'b1, 1'b0, 1'b1, 15'h0008, 32'h1c00_0102);
      step(); wb_ex = 1'b1; ex_entry = 32'h1c00_8000; #3;
      check_entry("adef.ex", 1'b1, 1'b1, 1'b1, 15'h0008, 32'h1c00_0106);

      // Buffered branch overwritten by exception; later branch must not displace it.
      step(); wb_ex = 1'b0; br_bus = {1'b0, 1'b1, 32'h1c00_0200}; #3;
      check_req("buf.br", 1'b1, 32'h1c00_8000);
      step(); br_bus = 34'd0; wb_ex = 1'b1; ex_entry = 32'h1c00_8040; #3;
      check_req("buf.ex", 1'b1, 32'h1c00_8000);
      step(); wb_ex = 1'b0; br_bus = {1'b0, 1'b1, 32'h1c00_0300}; #3;
      check("buf.br2.valid", 64'(ps_to_fs_valid), 64'd0);
      step(); br_bus = 34'd0; inst_sram_addr_ok = 1'b1; #3;
      check_entry("buf.fwd", 1'b1, 1'b1, 1'b0, 15'd0, 32'h1c00_8000);
      step(); inst_sram_addr_ok = 1'b0; #3;
      check_req("buf.new", 1'b1, 32'h1c00_8040);

      // Reset while requesting: outputs drop, buffer discarded, restart at RESET_PC.
      br_bus = {1'b0, 1'b1, 32'h1c00_0400}; reset = 1'b1;
      step(); br_bus = 34'd0; #3;
      check_req("mid.rst", 1'b0, 32'd0);
      check("mid.rst.valid", 64'(ps_to_fs_valid), 64'd0);
      step(); reset = 1'b0; inst_sram_addr_ok = 1'b1; #3;
      check_req("mid.idle", 1'b0, 32'd0);
      step(); #3;
      check_req("restart", 1'b1, 32'h1c00_0000);
      check_entry("restart", 1'b1, 1'b0, 1'b0, 15'd0, 32'h1c00_0000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
